cdc_reset_seq: RTL and testbench
================================

Name: cdc_reset_seq

Overview:
- Parametrised reset synchroniser and sequencer for one clock domain.
- Asserts all outputs asynchronously on `reset`, deasserts internal reset synchronously through a SYNC_FF-deep chain, then stretches reset for a minimum hold.
- Waits for a release gate, then releases NUM_CH reset channels in order, STEP_CYC cycles apart.
- Supports a synchronous software reset request; sits at the root of each clock domain (HyperRAM PHY, controller, bus bridge).

Parameters:
- NUM_CH, 3, number of sequenced reset outputs; legal range 1-16.
- SYNC_FF, 4, synchroniser depth in flops; legal range 2-10.
- HOLD_CYC, 16, cycles reset is stretched after synchronised deassertion; must be >=1.
- STEP_CYC, 8, cycles between successive channel releases; must be >=1.

Ports:
- clk_dst  input  1  destination clock; all logic single-clock.
- reset  input  1  asynchronous, active-high reset; any source domain.
- sw_reset  input  1  synchronous to clk_dst; active-high request to re-run the sequence.
- rel_ok  input  1  synchronous to clk_dst; release gate (e.g. PLL locked, already synchronised).
- rst_out  output  NUM_CH  active-high channel resets; bit 0 is released first.
- seq_done  output  1  high once every channel has been released.

Behaviour:
- Reset convention: reset is asynchronous and active-high; clock is clk_dst.
- `reset` high, asynchronously and immediately:
  - rst_out = all ones, seq_done = 0.
  - Synchroniser chain set to 1, state = HOLD, counter = 0.
- Synchroniser:
  - Chain shifts in 0 each edge while `reset` is low.
  - Internal reset rst_i falls at the SYNC_FF-th edge that samples `reset` low.
  - rst_i asynchronously resets the FSM and counters.
- FSM states are HOLD, GATE, STEP, RUN.
  - HOLD: counter increments each edge. At cnt==HOLD_CYC-1, go to GATE and clear cnt.
  - GATE: on an edge sampling rel_ok=1, clear rst_out[0]. Go to STEP, or to RUN if NUM_CH==1. While rel_ok=0, stay in GATE indefinitely.
  - STEP: cnt counts to STEP_CYC-1, then clears rst_out[idx+1], increments idx and clears cnt. When the last bit clears, go to RUN.
  - RUN: hold all outputs. rel_ok is ignored in STEP and RUN; it is sampled only in GATE.
- seq_done is registered high on the same edge that clears rst_out[NUM_CH-1].
- Timing with rel_ok tied high, edge 1 = first edge sampling `reset` low:
  - rst_out[k] falls at edge SYNC_FF+HOLD_CYC+1+k*STEP_CYC.
- rst_out bits only ever fall in index order. Once clear, a bit stays clear until sw_reset or reset.
- sw_reset=1 sampled in any state:
  - Next edge: rst_out = all ones, seq_done = 0, state = HOLD, cnt = 0, idx = 0.
  - While sw_reset is held high, stay in HOLD with cnt held at 0; HOLD counting starts on the first edge sampling sw_reset low.
  - sw_reset takes priority over every FSM transition on the same edge.
- `reset` reasserted mid-sequence: immediate asynchronous return to the full reset state, overriding everything.
- Counter width = clog2(max(HOLD_CYC,STEP_CYC)+1). idx width = clog2(NUM_CH) with a minimum of 1. No wrap: counters clear on every transition.
- Elaboration error if any parameter is outside its legal range.

Optional Feature:
- Macro: CDC_RESET_SEQ_CNT_EN.
- With the macro defined:
  - Extra output rst_cnt [7:0], a saturating count of accepted sw_reset requests (rising edges of sw_reset).
  - Cleared only by `reset`, not by sw_reset. Sticks at 255.
  - Updates on the edge after the rising edge is sampled.
- Without the macro: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cdc_reset_pkg holds:
  - State encoding for HOLD/GATE/STEP/RUN.
  - Parameter range constants (NUM_CH_MAX=16, SYNC_FF_MIN=2, SYNC_FF_MAX=10).
  - RST_CNT_W=8.
- Sub-module cdc_reset_sync:
  - SYNC_FF-deep chain, async assert / sync deassert, carrying the ASYNC_REG attribute.
  - Instantiated once for rst_i.

Test Plan:
- Defaults, rel_ok=1, reset released before edge 1 -> rst_out 111→110 at edge 21, 100 at edge 29, 000 at edge 37; seq_done rises at edge 37.
- rel_ok=0 until edge 50 -> rst_out stays 111 through edge 49; bit0 falls at the first edge sampling rel_ok=1; bits 1 and 2 fall 8 and 16 edges later.
- sw_reset pulsed 1 cycle at edge 32 (rst_out=100) -> edge 33 rst_out=111, seq_done=0; bit0 falls at edge 50 (16 HOLD + 1 GATE cycles after sw_reset).
- reset pulsed mid-STEP for 3 ns (asynchronous, off-edge) -> rst_out=111 immediately; full sequence restarts; a pulse shorter than one period still triggers it.
- NUM_CH=1, SYNC_FF=2, HOLD_CYC=1, STEP_CYC=1 -> rst_out falls and seq_done rises at edge 4.
- With CDC_RESET_SEQ_CNT_EN, 300 sw_reset pulses -> rst_cnt saturates at 255; the next `reset` clears it to 0.

Source files
------------

// File: rtl/cdc_reset_pkg.sv
// Shared types and limits for the cdc_reset_seq reset sequencer.
// Optional sw_reset request counter is enabled with CDC_RESET_SEQ_CNT_EN.
package cdc_reset_pkg;

  localparam int unsigned NUM_CH_MIN   = 1;
  localparam int unsigned NUM_CH_MAX   = 16;
  localparam int unsigned SYNC_FF_MIN  = 2;
  localparam int unsigned SYNC_FF_MAX  = 10;
  localparam int unsigned HOLD_CYC_MIN = 1;
  localparam int unsigned STEP_CYC_MIN = 1;
  localparam int unsigned RST_CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_GATE = 2'd1,
    ST_STEP = 2'd2,
    ST_RUN  = 2'd3
  } seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cdc_reset_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after SYNC_FF edges of clk_dst.
module cdc_reset_sync
  import cdc_reset_pkg::*;
#(
  parameter int unsigned SYNC_FF = 4
) (
  input  logic clk_dst,
  input  logic reset,
  output logic rst_sync
);

  if (SYNC_FF < SYNC_FF_MIN || SYNC_FF > SYNC_FF_MAX) begin : g_bad_sync_ff
    $error("cdc_reset_sync: SYNC_FF out of range");
  end

  (* ASYNC_REG = "TRUE" *) logic [SYNC_FF-1:0] chain_q;

  always_ff @(posedge clk_dst or posedge reset) begin
    if (reset) begin
      chain_q <= '1;
    end else begin
      chain_q <= {chain_q[SYNC_FF-2:0], 1'b0};
    end
  end

  assign rst_sync = chain_q[SYNC_FF-1];

endmodule

// File: rtl/cdc_reset_seq.sv
// Reset synchroniser and sequencer: stretches reset, waits for rel_ok, then releases
// rst_out bits in index order. Define CDC_RESET_SEQ_CNT_EN to add the rst_cnt output.
module cdc_reset_seq
  import cdc_reset_pkg::*;
#(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned SYNC_FF  = 4,
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned STEP_CYC = 8
) (
  input  logic                 clk_dst,
  input  logic                 reset,
  input  logic                 sw_reset,
  input  logic                 rel_ok,
  output logic [NUM_CH-1:0]    rst_out,
  output logic                 seq_done
`ifdef CDC_RESET_SEQ_CNT_EN
  ,
  output logic [RST_CNT_W-1:0] rst_cnt
`endif
);

  localparam int unsigned CNT_W    = $clog2(max_u(HOLD_CYC, STEP_CYC) + 1);
  localparam int unsigned IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned LAST_IDX = (NUM_CH > 1) ? (NUM_CH - 2) : 0;

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
    $error("cdc_reset_seq: NUM_CH out of range");
  end
  if (SYNC_FF < SYNC_FF_MIN || SYNC_FF > SYNC_FF_MAX) begin : g_bad_sync_ff
    $error("cdc_reset_seq: SYNC_FF out of range");
  end
  if (HOLD_CYC < HOLD_CYC_MIN) begin : g_bad_hold
    $error("cdc_reset_seq: HOLD_CYC must be at least 1");
  end
  if (STEP_CYC < STEP_CYC_MIN) begin : g_bad_step
    $error("cdc_reset_seq: STEP_CYC must be at least 1");
  end

  logic rst_i;

  cdc_reset_sync #(
    .SYNC_FF (SYNC_FF)
  ) u_sync (
    .clk_dst  (clk_dst),
    .reset    (reset),
    .rst_sync (rst_i)
  );

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] rst_out_q, rst_out_d;
  logic              seq_done_q, seq_done_d;

  always_ff @(posedge clk_dst or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_out_q  <= '1;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rst_out_q  <= rst_out_d;
      seq_done_q <= seq_done_d;
    end
  end

  // Bits clear in index order, so releasing the next channel is a left shift of zeros.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rst_out_d  = rst_out_q;
    seq_done_d = seq_done_q;

    if (sw_reset) begin
      state_d    = ST_HOLD;
      cnt_d      = '0;
      idx_d      = '0;
      rst_out_d  = '1;
      seq_done_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
            state_d = ST_GATE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_GATE: begin
          if (rel_ok) begin
            rst_out_d = rst_out_q << 1;
            cnt_d     = '0;
            idx_d     = '0;
            if (NUM_CH == 1) begin
              state_d    = ST_RUN;
              seq_done_d = 1'b1;
            end else begin
              state_d = ST_STEP;
            end
          end
        end
        ST_STEP: begin
          if (cnt_q == CNT_W'(STEP_CYC - 1)) begin
            rst_out_d = rst_out_q << 1;
            cnt_d     = '0;
            if (idx_q == IDX_W'(LAST_IDX)) begin
              state_d    = ST_RUN;
              seq_done_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign rst_out  = rst_out_q;
  assign seq_done = seq_done_q;

`ifdef CDC_RESET_SEQ_CNT_EN
  // Saturating count of sw_reset rising edges; survives sw_reset, cleared only by reset.
  logic                 sw_q;
  logic                 rise_q;
  logic [RST_CNT_W-1:0] rst_cnt_q;

  always_ff @(posedge clk_dst or posedge reset) begin
    if (reset) begin
      sw_q      <= 1'b0;
      rise_q    <= 1'b0;
      rst_cnt_q <= '0;
    end else begin
      sw_q   <= sw_reset;
      rise_q <= sw_reset & ~sw_q;
      if (rise_q && (rst_cnt_q != '1)) begin
        rst_cnt_q <= rst_cnt_q + RST_CNT_W'(1);
      end
    end
  end

  assign rst_cnt = rst_cnt_q;
`endif

endmodule

// File: tb/tb_cdc_reset_seq.sv
// Directed bench for cdc_reset_seq (default and minimal configurations).
// Define CDC_RESET_SEQ_CNT_EN to also exercise the rst_cnt output.
module tb_cdc_reset_seq;

  logic       clk_dst = 1'b0;
  logic       reset;
  logic       sw_reset;
  logic       rel_ok;
  logic [2:0] rst_out;
  logic       seq_done;
  logic       reset1;
  logic [0:0] rst_out1;
  logic       seq_done1;
`ifdef CDC_RESET_SEQ_CNT_EN
  logic [7:0] rst_cnt;
  logic [7:0] rst_cnt1;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk_dst = ~clk_dst;

  cdc_reset_seq dut (
    .clk_dst  (clk_dst),
    .reset    (reset),
    .sw_reset (sw_reset),
    .rel_ok   (rel_ok),
    .rst_out  (rst_out),
    .seq_done (seq_done)
`ifdef CDC_RESET_SEQ_CNT_EN
    ,
    .rst_cnt  (rst_cnt)
`endif
  );

  cdc_reset_seq #(
    .NUM_CH   (1),
    .SYNC_FF  (2),
    .HOLD_CYC (1),
    .STEP_CYC (1)
  ) dut1 (
    .clk_dst  (clk_dst),
    .reset    (reset1),
    .sw_reset (1'b0),
    .rel_ok   (1'b1),
    .rst_out  (rst_out1),
    .seq_done (seq_done1)
`ifdef CDC_RESET_SEQ_CNT_EN
    ,
    .rst_cnt  (rst_cnt1)
`endif
  );

  // Expected rst_out for the default config given the edge at which bit 0 falls.
  function automatic logic [2:0] exp_rst(input int e, input int t0);
    if (e >= t0 + 16) return 3'b000;
    if (e >= t0 + 8)  return 3'b100;
    if (e >= t0)      return 3'b110;
    return 3'b111;
  endfunction

  task automatic tick();
    @(posedge clk_dst);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    reset1   = 1'b1;
    sw_reset = 1'b0;
    rel_ok   = 1'b1;
    repeat (3) tick();
    compared++;
    if (rst_out !== 3'b111) begin
      mismatched++;
      $display("FAIL reset_rst_out: got %b expected %b", rst_out, 3'b111);
    end
    compared++;
    if (seq_done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_seq_done: got %b expected 0", seq_done);
    end
    compared++;
    if (rst_out1 !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_rst_out1: got %b expected 1", rst_out1);
    end
  endtask

  task automatic test_default_seq();
    reset = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      compared++;
      if (rst_out !== exp_rst(e, 21)) begin
        mismatched++;
        $display("FAIL default_rst_out edge %0d: got %b expected %b", e, rst_out, exp_rst(e, 21));
      end
      compared++;
      if (seq_done !== (e >= 37)) begin
        mismatched++;
        $display("FAIL default_seq_done edge %0d: got %b expected %b", e, seq_done, (e >= 37));
      end
    end
  endtask

  task automatic test_gate();
    reset  = 1'b1;
    rel_ok = 1'b0;
    #1;
    compared++;
    if (rst_out !== 3'b111 || seq_done !== 1'b0) begin
      mismatched++;
      $display("FAIL gate_async_assert: got %b/%b expected 111/0", rst_out, seq_done);
    end
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 70; e++) begin
      if (e == 50) rel_ok = 1'b1;
      tick();
      compared++;
      if (rst_out !== exp_rst(e, 50)) begin
        mismatched++;
        $display("FAIL gate_rst_out edge %0d: got %b expected %b", e, rst_out, exp_rst(e, 50));
      end
      compared++;
      if (seq_done !== (e >= 66)) begin
        mismatched++;
        $display("FAIL gate_seq_done edge %0d: got %b expected %b", e, seq_done, (e >= 66));
      end
    end
  endtask

  task automatic test_sw_reset();
    logic [2:0] exp;
    logic       exp_done;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 66; e++) begin
      if (e == 33) sw_reset = 1'b1;
      if (e == 34) sw_reset = 1'b0;
      tick();
      exp      = (e < 33) ? exp_rst(e, 21) : exp_rst(e, 50);
      exp_done = (e < 33) ? 1'b0 : (e >= 66);
      compared++;
      if (rst_out !== exp) begin
        mismatched++;
        $display("FAIL sw_rst_out edge %0d: got %b expected %b", e, rst_out, exp);
      end
      compared++;
      if (seq_done !== exp_done) begin
        mismatched++;
        $display("FAIL sw_seq_done edge %0d: got %b expected %b", e, seq_done, exp_done);
      end
    end
  endtask

  task automatic test_sw_hold();
    for (int e = 1; e <= 23; e++) begin
      if (e == 1) sw_reset = 1'b1;
      if (e == 6) sw_reset = 1'b0;
      tick();
      compared++;
      if (rst_out !== exp_rst(e, 22) || seq_done !== 1'b0) begin
        mismatched++;
        $display("FAIL sw_hold edge %0d: got %b/%b expected %b/0", e, rst_out, seq_done, exp_rst(e, 22));
      end
    end
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if (rst_out !== 3'b111 || seq_done !== 1'b0) begin
      mismatched++;
      $display("FAIL async_assert: got %b/%b expected 111/0", rst_out, seq_done);
    end
    #2;
    reset = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      compared++;
      if (rst_out !== exp_rst(e, 21)) begin
        mismatched++;
        $display("FAIL async_rst_out edge %0d: got %b expected %b", e, rst_out, exp_rst(e, 21));
      end
      compared++;
      if (seq_done !== (e >= 37)) begin
        mismatched++;
        $display("FAIL async_seq_done edge %0d: got %b expected %b", e, seq_done, (e >= 37));
      end
    end
  endtask

  task automatic test_small();
    reset1 = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      compared++;
      if (rst_out1 !== ((e >= 4) ? 1'b0 : 1'b1)) begin
        mismatched++;
        $display("FAIL small_rst_out edge %0d: got %b expected %b", e, rst_out1, (e < 4));
      end
      compared++;
      if (seq_done1 !== (e >= 4)) begin
        mismatched++;
        $display("FAIL small_seq_done edge %0d: got %b expected %b", e, seq_done1, (e >= 4));
      end
    end
  endtask

`ifdef CDC_RESET_SEQ_CNT_EN
  task automatic test_sw_count();
    compared++;
    if (rst_cnt !== 8'd0 || rst_cnt1 !== 8'd0) begin
      mismatched++;
      $display("FAIL cnt_start: got %0d/%0d expected 0/0", rst_cnt, rst_cnt1);
    end
    sw_reset = 1'b1;
    tick();
    compared++;
    if (rst_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL cnt_latency: got %0d expected 0", rst_cnt);
    end
    sw_reset = 1'b0;
    tick();
    compared++;
    if (rst_cnt !== 8'd1) begin
      mismatched++;
      $display("FAIL cnt_first: got %0d expected 1", rst_cnt);
    end
    for (int p = 2; p <= 300; p++) begin
      sw_reset = 1'b1;
      tick();
      sw_reset = 1'b0;
      tick();
      if (p == 254) begin
        compared++;
        if (rst_cnt !== 8'd254) begin
          mismatched++;
          $display("FAIL cnt_254: got %0d expected 254", rst_cnt);
        end
      end
    end
    repeat (2) tick();
    compared++;
    if (rst_cnt !== 8'd255) begin
      mismatched++;
      $display("FAIL cnt_saturate: got %0d expected 255", rst_cnt);
    end
    reset = 1'b1;
    #1;
    compared++;
    if (rst_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL cnt_clear: got %0d expected 0", rst_cnt);
    end
    tick();
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_default_seq();
    test_gate();
    test_sw_reset();
    test_sw_hold();
    test_async_reset();
    test_small();
`ifdef CDC_RESET_SEQ_CNT_EN
    test_sw_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
